// File: rtl/vga_pkg.sv
// Shared VGA definitions: receiver FSM states and 640x480@60 default timing,
// used by both the vga_sync source and the vga_sync_rx receiver.
package vga_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_H_TOTAL  = 800;
  localparam int VGA_V_TOTAL  = 525;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_V_SYNC   = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for one sync line, plus leading/trailing edge pulses
// taken from the synchronised level. POL gives the asserted level.
module sync_edge_det #(
  parameter bit POL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_in,
  output logic lead,
  output logic trail
);

  logic meta;
  logic sync_q;
  logic sync_d;
  logic now_active;
  logic was_active;

  // Flops start at the deasserted level so reset release cannot fake a trailing edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= ~POL;
      sync_q <= ~POL;
      sync_d <= ~POL;
    end else begin
      meta   <= sync_in;
      sync_q <= meta;
      sync_d <= sync_q;
    end
  end

  assign now_active = (sync_q == POL);
  assign was_active = (sync_d == POL);
  assign lead       = now_active & ~was_active;
  assign trail      = ~now_active & was_active;

endmodule

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: measures line/frame timing, locks after repeated matching
// frames and regenerates pixel_x/pixel_y/video_on aligned with the delayed rgb.
module vga_sync_rx
  import vga_pkg::*;
#(
  parameter int CW       = 12,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_BP     = VGA_V_BP,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter bit SYNC_POL = 1'b0,
  parameter int LOCK_FRM = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [2:0]    rgb_in,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          video_on,
  output logic [2:0]    rgb_out,
  output logic          locked,
  output logic [CW-1:0] h_total,
  output logic [CW-1:0] v_total,
  output logic          frame_start,
  output logic          timing_err
);

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] H_BP_C   = CW'(H_BP);
  localparam logic [CW-1:0] V_BP_C   = CW'(V_BP);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [7:0]    LOCK_TGT = 8'(LOCK_FRM - 1);

  logic hs_lead, hs_trail, vs_lead, vs_trail;
  logic [2:0] rgb_meta, rgb_sync;

  logic [CW-1:0] h_cnt, v_cnt, hs_w, vs_w;
  logic [CW-1:0] cand_h, prev_h, prev_v;
  logic [7:0]    match_cnt;
  rx_state_t     state;

  logic [CW-1:0] h_len, v_len, h_cur, v_cur, cand_h_now;
  logic [CW-1:0] h_start, v_start;
  logic          sat, in_h, in_v, vid_nx;

  rx_state_t     state_nx;
  logic [7:0]    match_nx;
  logic [CW-1:0] prev_h_nx, prev_v_nx;
  logic          lock_load, err_nx;

  sync_edge_det #(.POL(SYNC_POL)) u_hs_det (
    .clk     (clk),
    .reset_n (reset_n),
    .sync_in (hsync_in),
    .lead    (hs_lead),
    .trail   (hs_trail)
  );

  sync_edge_det #(.POL(SYNC_POL)) u_vs_det (
    .clk     (clk),
    .reset_n (reset_n),
    .sync_in (vsync_in),
    .lead    (vs_lead),
    .trail   (vs_trail)
  );

  // h_cnt/v_cnt hold the position of the previous synchronised sample;
  // h_cur/v_cur are the position of the sample being registered now.
  assign sat        = (h_cnt == CNT_MAX);
  assign h_len      = h_cnt + ONE;
  assign v_len      = v_cnt + ONE;
  assign h_cur      = hs_lead ? '0 : (sat ? CNT_MAX : h_len);
  assign v_cur      = vs_lead ? '0 : (hs_lead ? v_len : v_cnt);
  assign cand_h_now = hs_lead ? h_len : cand_h;

  assign h_start = hs_w + H_BP_C;
  assign v_start = vs_w + V_BP_C;
  assign in_h    = (h_cur >= h_start) && (h_cur < h_start + H_ACT_C);
  assign in_v    = (v_cur >= v_start) && (v_cur < v_start + V_ACT_C);
  assign vid_nx  = (state_nx == LOCKED) && in_h && in_v;

  // Lock FSM; a saturated h_cnt means the source vanished and overrides everything.
  always_comb begin
    state_nx  = state;
    match_nx  = match_cnt;
    prev_h_nx = prev_h;
    prev_v_nx = prev_v;
    lock_load = 1'b0;
    err_nx    = 1'b0;
    if (sat) begin
      state_nx = SEARCH;
    end else begin
      case (state)
        SEARCH: begin
          if (vs_lead) begin
            state_nx  = MEASURE;
            match_nx  = '0;
            prev_h_nx = '0;
            prev_v_nx = '0;
          end
        end
        MEASURE: begin
          if (vs_lead) begin
            if (cand_h_now == prev_h && v_len == prev_v) begin
              match_nx = match_cnt + 8'd1;
              if (match_nx == LOCK_TGT) begin
                state_nx  = LOCKED;
                lock_load = 1'b1;
              end
            end else begin
              prev_h_nx = cand_h_now;
              prev_v_nx = v_len;
              match_nx  = '0;
            end
          end
        end
        LOCKED: begin
          if ((hs_lead && h_len != h_total) || (vs_lead && v_len != v_total)) begin
            err_nx   = 1'b1;
            state_nx = SEARCH;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= SEARCH;
      match_cnt <= '0;
      prev_h    <= '0;
      prev_v    <= '0;
      cand_h    <= '0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      hs_w      <= '0;
      vs_w      <= '0;
      h_total   <= '0;
      v_total   <= '0;
      locked    <= 1'b0;
    end else begin
      state     <= state_nx;
      match_cnt <= match_nx;
      prev_h    <= prev_h_nx;
      prev_v    <= prev_v_nx;
      h_cnt     <= h_cur;
      v_cnt     <= v_cur;
      locked    <= (state_nx == LOCKED);
      if (hs_lead)   cand_h  <= h_len;
      if (hs_trail)  hs_w    <= h_cur;
      if (vs_trail)  vs_w    <= v_cur;
      if (lock_load) begin
        h_total <= cand_h_now;
        v_total <= v_len;
      end
    end
  end

  // rgb takes the same two-flop path as the syncs so the output register lines them up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_meta    <= '0;
      rgb_sync    <= '0;
      rgb_out     <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
    end else begin
      rgb_meta    <= rgb_in;
      rgb_sync    <= rgb_meta;
      rgb_out     <= vid_nx ? rgb_sync : 3'b000;
      pixel_x     <= vid_nx ? (h_cur - h_start) : '0;
      pixel_y     <= vid_nx ? (v_cur - v_start) : '0;
      video_on    <= vid_nx;
      frame_start <= vs_lead;
      timing_err  <= err_nx;
    end
  end

endmodule

// File: tb/tb_vga_sync_rx.sv
// Scoreboard bench for vga_sync_rx on a small 17x9 raster: stimulus pushes
// expected pixels and event cycles, a negedge monitor pops and compares them.
module tb_vga_sync_rx;

  localparam int HS = 4, HBP = 3, HACT = 8, HTOT = 17;
  localparam int VS = 2, VBP = 2, VACT = 4, VTOT = 9;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [2:0]  rgb_in = 3'b000;
  logic [11:0] pixel_x, pixel_y, h_total, v_total;
  logic [2:0]  rgb_out;
  logic        video_on, locked, frame_start, timing_err;

  vga_sync_rx #(
    .CW(12), .H_BP(HBP), .V_BP(VBP), .H_ACTIVE(HACT), .V_ACTIVE(VACT),
    .SYNC_POL(1'b0), .LOCK_FRM(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .rgb_in(rgb_in), .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
    .rgb_out(rgb_out), .locked(locked), .h_total(h_total), .v_total(v_total),
    .frame_start(frame_start), .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [2:0]  rgb;
  } pix_t;

  pix_t pix_q[$];
  int   fs_q[$], err_q[$], rise_q[$], fall_q[$];
  int   checks = 0;
  int   errors = 0;

  // Source/receiver model state
  int vs_count = 0;
  bit m_locked = 1'b0;
  int prev_len = HTOT;
  int last_hs_lead = 0;

  task automatic check_output(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic flag_unexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s got unexpected event expected none (cycle %0d)", name, cyc);
  endtask

  function automatic logic [2:0] pix_colour(input int x, input int y);
    if (x == 0 && y == 0) return 3'b101;
    return 3'((x ^ y) & 3);
  endfunction

  // One source clock at raster position (l,h) of a line that is len clocks long.
  task automatic apply_stimulus(input int l, input int h, input int len);
    bit err_now;
    @(posedge clk);
    #1;
    err_now  = 1'b0;
    hsync_in = (h < HS) ? 1'b0 : 1'b1;
    vsync_in = (l < VS) ? 1'b0 : 1'b1;
    if (h == 0) begin
      last_hs_lead = cyc;
      if (m_locked && prev_len != HTOT) begin
        err_q.push_back(cyc + LAT);
        fall_q.push_back(cyc + LAT);
        m_locked = 1'b0;
        vs_count = 0;
        err_now  = 1'b1;
      end
      if (l == 0) begin
        fs_q.push_back(cyc + LAT);
        if (!err_now) vs_count++;
        if (!m_locked && vs_count >= 3) begin
          m_locked = 1'b1;
          rise_q.push_back(cyc + LAT);
        end
      end
    end
    if (h >= HS + HBP && h < HS + HBP + HACT && l >= VS + VBP && l < VS + VBP + VACT) begin
      rgb_in = pix_colour(h - HS - HBP, l - VS - VBP);
      if (m_locked)
        pix_q.push_back({12'(h - HS - HBP), 12'(l - VS - VBP), rgb_in});
    end else begin
      rgb_in = 3'b111;
    end
    if (h == len - 1) prev_len = len;
  endtask

  task automatic assert_reset();
    #2;
    reset_n = 1'b0;
    if (m_locked) fall_q.push_back(cyc);
    m_locked = 1'b0;
    vs_count = 0;
    pix_q.delete();
    #1;
    check_output("rst_locked", int'(locked), 0);
    check_output("rst_video_on", int'(video_on), 0);
    check_output("rst_pixel_xy", int'({pixel_x, pixel_y}), 0);
    check_output("rst_rgb_out", int'(rgb_out), 0);
    check_output("rst_totals", int'({h_total, v_total}), 0);
    check_output("rst_pulses", int'({frame_start, timing_err}), 0);
  endtask

  task automatic drive_frame(input int short_line, input int rst_line);
    for (int l = 0; l < VTOT; l++) begin
      int len;
      len = (l == short_line) ? HTOT - 1 : HTOT;
      for (int h = 0; h < len; h++) begin
        apply_stimulus(l, h, len);
        if (l == rst_line && h == 1) assert_reset();
        if (l == rst_line && h == 9) reset_n = 1'b1;
      end
    end
  endtask

  // Monitor: every DUT event must match the head of its queue.
  logic locked_prev = 1'b0;
  always @(negedge clk) begin
    if (frame_start) begin
      if (fs_q.size() == 0) flag_unexpected("frame_start");
      else check_output("frame_start_cycle", cyc, fs_q.pop_front());
    end
    if (timing_err) begin
      if (err_q.size() == 0) flag_unexpected("timing_err");
      else check_output("timing_err_cycle", cyc, err_q.pop_front());
    end
    if (locked && !locked_prev) begin
      if (rise_q.size() == 0) flag_unexpected("locked_rise");
      else check_output("locked_rise_cycle", cyc, rise_q.pop_front());
      check_output("h_total", int'(h_total), HTOT);
      check_output("v_total", int'(v_total), VTOT);
    end
    if (!locked && locked_prev) begin
      if (fall_q.size() == 0) flag_unexpected("locked_fall");
      else check_output("locked_fall_cycle", cyc, fall_q.pop_front());
    end
    if (video_on) begin
      if (pix_q.size() == 0) flag_unexpected("video_on");
      else begin
        pix_t p;
        p = pix_q.pop_front();
        check_output("pixel_x", int'(pixel_x), int'(p.x));
        check_output("pixel_y", int'(pixel_y), int'(p.y));
        check_output("rgb_out", int'(rgb_out), int'(p.rgb));
      end
    end else begin
      check_output("idle_xy_rgb", int'({pixel_x, pixel_y, rgb_out}), 0);
    end
    locked_prev <= locked;
  end

  initial begin
    $display("[TB] vga_sync_rx bench start");
    repeat (3) @(posedge clk);
    #1;
    check_output("init_locked", int'(locked), 0);
    check_output("init_totals", int'({h_total, v_total}), 0);
    check_output("init_pulses", int'({frame_start, timing_err, video_on}), 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Initial lock on the third frame, then a fully locked frame
    for (int f = 0; f < 4; f++) drive_frame(-1, -1);

    // Reset at line 5 while locked, then re-lock
    drive_frame(-1, 5);
    for (int f = 0; f < 4; f++) drive_frame(-1, -1);

    // One 16-clock line while locked, then re-lock
    drive_frame(5, -1);
    for (int f = 0; f < 4; f++) drive_frame(-1, -1);

    // Source stops: h_cnt saturates and lock drops without an error pulse
    if (m_locked) fall_q.push_back(last_hs_lead + LAT + 4096);
    m_locked = 1'b0;
    @(posedge clk);
    #1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    rgb_in   = 3'b111;
    repeat (4300) @(posedge clk);
    #1;
    check_output("sat_locked", int'(locked), 0);

    @(negedge clk);
    check_output("pending_events",
                 pix_q.size() + fs_q.size() + err_q.size() + rise_q.size() + fall_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
